// File: rtl/sig_align_ctrl_if.sv
// sig_align_ctrl_if: operand-group and aligner-command bundle for sig_align_ctrl
interface sig_align_ctrl_if #(
  parameter int expWidth = 4,
  parameter int sigWidth = 4
);
  logic in_valid;
  logic in_ready;
  logic [4*expWidth-1:0] in_exp;
  logic [4*sigWidth-1:0] in_sig;
  logic [3:0] in_sign;
  logic [1:0] in_mode;
  logic cfg_we;
  logic [3:0] cfg_c1;
  logic [3:0] cfg_c2;
  logic out_valid;
  logic out_ready;
  logic [4*expWidth-1:0] exp_offset_num;
  logic [4*sigWidth-1:0] significand;
  logic [3:0] sign;
  logic [3:0] complement_sign1;
  logic [3:0] complement_sign2;
  logic [expWidth-1:0] max_exp;
  logic [15:0] stall_cnt;
  modport master (
    output in_valid, in_exp, in_sig, in_sign, in_mode, cfg_we, cfg_c1, cfg_c2, out_ready,
    input in_ready, out_valid, exp_offset_num, significand, sign,
    input complement_sign1, complement_sign2, max_exp, stall_cnt
  );
  modport slave (
    input in_valid, in_exp, in_sig, in_sign, in_mode, cfg_we, cfg_c1, cfg_c2, out_ready,
    output in_ready, out_valid, exp_offset_num, significand, sign,
    output complement_sign1, complement_sign2, max_exp, stall_cnt
  );
endinterface

// File: rtl/sig_align_ctrl.sv
// sig_align_ctrl: 2-stage aligner command sequencer; SIG_ALIGN_CTRL_ZERO_FLUSH_EN forces exp==0 lanes to full shift
module sig_align_ctrl #(
  parameter int expWidth = 4,
  parameter int sigWidth = 4,
  parameter int low_expand = 2
) (
  input logic clk,
  input logic rst_n,
  sig_align_ctrl_if.slave bus
);
  localparam int SAT = sigWidth + 3 + low_expand;
  localparam logic CLAMP = SAT < (2 ** expWidth);
  localparam logic [expWidth-1:0] SATV = expWidth'(SAT);
  logic s1_valid;
  logic s1_adv;
  logic accept;
  logic [4*expWidth-1:0] s1_exp;
  logic [4*expWidth-1:0] off;
  logic [4*sigWidth-1:0] s1_sig;
  logic [3:0] s1_sign;
  logic [3:0] s1_c1;
  logic [3:0] s1_c2;
  logic [3:0] pc1;
  logic [3:0] pc2;
  logic [3:0] c1;
  logic [3:0] c2;
  logic [expWidth-1:0] s1_max;
  logic [expWidth-1:0] m01;
  logic [expWidth-1:0] m23;
  logic [expWidth-1:0] mx;
  logic [expWidth-1:0] ie [4];
  assign s1_adv = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s1_adv;
  assign accept = bus.in_valid && bus.in_ready;
  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic [expWidth-1:0] e;
    logic [expWidth-1:0] d;
    assign ie[k] = bus.in_exp[expWidth*k +: expWidth];
    assign e = s1_exp[expWidth*k +: expWidth];
    assign d = s1_max - e;
`ifdef SIG_ALIGN_CTRL_ZERO_FLUSH_EN
    assign off[expWidth*k +: expWidth] = (e == '0 || (CLAMP && d >= SATV)) ? SATV : d;
`else
    assign off[expWidth*k +: expWidth] = (CLAMP && d >= SATV) ? SATV : d;
`endif
  end
  assign m01 = ie[0] > ie[1] ? ie[0] : ie[1];
  assign m23 = ie[2] > ie[3] ? ie[2] : ie[3];
  assign mx = m01 > m23 ? m01 : m23;
  assign c1 = bus.in_mode == 2'd3 ? pc1 : 4'b0000;
  assign c2 = bus.in_mode == 2'd0 ? 4'b0000 :
              bus.in_mode == 2'd1 ? 4'b1100 :
              bus.in_mode == 2'd2 ? 4'b1010 : pc2;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_exp <= '0;
      s1_sig <= '0;
      s1_sign <= '0;
      s1_max <= '0;
      s1_c1 <= '0;
      s1_c2 <= '0;
      pc1 <= 4'b0000;
      pc2 <= 4'b1111;
      bus.out_valid <= 1'b0;
      bus.exp_offset_num <= '0;
      bus.significand <= '0;
      bus.sign <= '0;
      bus.complement_sign1 <= '0;
      bus.complement_sign2 <= '0;
      bus.max_exp <= '0;
      bus.stall_cnt <= '0;
    end else begin
      if (bus.cfg_we) begin
        pc1 <= bus.cfg_c1;
        pc2 <= bus.cfg_c2;
      end
      if (bus.out_valid && !bus.out_ready && bus.stall_cnt != 16'hFFFF)
        bus.stall_cnt <= bus.stall_cnt + 16'd1;
      if (bus.in_ready)
        s1_valid <= bus.in_valid;
      if (accept) begin
        s1_exp <= bus.in_exp;
        s1_sig <= bus.in_sig;
        s1_sign <= bus.in_sign;
        s1_max <= mx;
        s1_c1 <= c1;
        s1_c2 <= c2;
      end
      if (s1_adv)
        bus.out_valid <= s1_valid;
      if (s1_adv && s1_valid) begin
        bus.exp_offset_num <= off;
        bus.significand <= s1_sig;
        bus.sign <= s1_sign;
        bus.complement_sign1 <= s1_c1;
        bus.complement_sign2 <= s1_c2;
        bus.max_exp <= s1_max;
      end
    end
  end
endmodule

// File: tb/tb_sig_align_ctrl.sv
// tb_sig_align_ctrl: table vectors, corner sequences and random traffic against a queue model
module tb_sig_align_ctrl;
  typedef struct {
    logic [15:0] exp;
    logic [15:0] sig;
    logic [3:0] sign;
    logic [1:0] mode;
    logic [15:0] off;
    logic [3:0] mx;
    logic [3:0] c1;
    logic [3:0] c2;
  } cmd_t;
  typedef struct {
    logic [15:0] sig;
    logic [3:0] c1;
    logic [3:0] c2;
    int t;
  } emit_t;
  localparam int SAT = 9;
  logic clk = 1'b0;
  logic rst_n;
  logic live = 1'b0;
  int checks = 0;
  int errors = 0;
  int tick_n = 0;
  int accepts = 0;
  int stalls = 0;
  logic [3:0] mc1 = 4'b0000;
  logic [3:0] mc2 = 4'b1111;
  cmd_t q[$];
  logic rdy[$];
  emit_t emitted[$];
  cmd_t vec[7];
  sig_align_ctrl_if bus();
  sig_align_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask
  function automatic cmd_t ref_cmd(input logic [15:0] e, input logic [15:0] s, input logic [3:0] sg, input logic [1:0] m);
    cmd_t c;
    int mx;
    int d;
    mx = 0;
    c.exp = e;
    c.sig = s;
    c.sign = sg;
    c.mode = m;
    c.off = '0;
    for (int i = 0; i < 4; i++)
      if (int'(e[4*i +: 4]) > mx) mx = int'(e[4*i +: 4]);
    for (int i = 0; i < 4; i++) begin
      d = mx - int'(e[4*i +: 4]);
`ifdef SIG_ALIGN_CTRL_ZERO_FLUSH_EN
      if (e[4*i +: 4] == 4'd0) d = SAT;
`endif
      if (d > SAT) d = SAT;
      c.off[4*i +: 4] = 4'(d);
    end
    c.mx = 4'(mx);
    c.c1 = m == 2'd3 ? mc1 : 4'b0000;
    c.c2 = m == 2'd0 ? 4'b0000 : m == 2'd1 ? 4'b1100 : m == 2'd2 ? 4'b1010 : mc2;
    return c;
  endfunction
  task automatic drive(input logic v, input logic [15:0] e, input logic [15:0] s, input logic [3:0] sg, input logic [1:0] m);
    bus.in_valid = v;
    bus.in_exp = e;
    bus.in_sig = s;
    bus.in_sign = sg;
    bus.in_mode = m;
  endtask
  task automatic tick();
    logic exp_rdy;
    logic acc;
    logic con;
    logic stl;
    logic we;
    logic [3:0] w1;
    logic [3:0] w2;
    cmd_t nc;
    #1;
    exp_rdy = !(q.size() == 2 && !bus.out_ready);
    if (live) chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    acc = bus.in_valid && exp_rdy;
    con = q.size() > 0 && rdy[0] && bus.out_ready;
    stl = q.size() > 0 && rdy[0] && !bus.out_ready;
    we = bus.cfg_we;
    w1 = bus.cfg_c1;
    w2 = bus.cfg_c2;
    nc = ref_cmd(bus.in_exp, bus.in_sig, bus.in_sign, bus.in_mode);
    if (live && rst_n && bus.out_valid === 1'b1 && bus.out_ready)
      emitted.push_back('{bus.significand, bus.complement_sign1, bus.complement_sign2, tick_n});
    @(posedge clk);
    tick_n++;
    if (!rst_n) begin
      q.delete();
      rdy.delete();
      stalls = 0;
      mc1 = 4'b0000;
      mc2 = 4'b1111;
      live = 1'b1;
    end else if (live) begin
      if (stl && stalls < 65535) stalls++;
      if (con) begin
        q.delete(0);
        rdy.delete(0);
      end
      foreach (rdy[i]) rdy[i] = 1'b1;
      if (acc) begin
        q.push_back(nc);
        rdy.push_back(1'b0);
        accepts++;
      end
      if (we) begin
        mc1 = w1;
        mc2 = w2;
      end
    end
    #1;
    if (live) begin
      chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0 && rdy[0]));
      chk("stall_cnt", 32'(bus.stall_cnt), 32'(stalls));
      if (q.size() > 0 && rdy[0]) begin
        chk("exp_offset_num", 32'(bus.exp_offset_num), 32'(q[0].off));
        chk("max_exp", 32'(bus.max_exp), 32'(q[0].mx));
        chk("significand", 32'(bus.significand), 32'(q[0].sig));
        chk("sign", 32'(bus.sign), 32'(q[0].sign));
        chk("complement_sign1", 32'(bus.complement_sign1), 32'(q[0].c1));
        chk("complement_sign2", 32'(bus.complement_sign2), 32'(q[0].c2));
      end
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask
  initial begin
    int gi;
    int a0;
    vec[0] = '{16'h3757, 16'hA5C3, 4'b1011, 2'b01, 16'h4020, 4'd7, 4'b0000, 4'b1100};
    vec[1] = '{16'hFF1F, 16'h1234, 4'b0100, 2'b10, 16'h0090, 4'd15, 4'b0000, 4'b1010};
`ifdef SIG_ALIGN_CTRL_ZERO_FLUSH_EN
    vec[2] = '{16'h4240, 16'h5A5A, 4'b0001, 2'b00, 16'h0209, 4'd4, 4'b0000, 4'b0000};
    vec[4] = '{16'h0000, 16'hFFFF, 4'b1111, 2'b01, 16'h9999, 4'd0, 4'b0000, 4'b1100};
`else
    vec[2] = '{16'h4240, 16'h5A5A, 4'b0001, 2'b00, 16'h0204, 4'd4, 4'b0000, 4'b0000};
    vec[4] = '{16'h0000, 16'hFFFF, 4'b1111, 2'b01, 16'h0000, 4'd0, 4'b0000, 4'b1100};
`endif
    vec[3] = '{16'h4321, 16'h0F0E, 4'b1000, 2'b11, 16'h0123, 4'd4, 4'b0000, 4'b1111};
    vec[5] = '{16'hC13C, 16'h8001, 4'b0110, 2'b10, 16'h0990, 4'd12, 4'b0000, 4'b1010};
    vec[6] = '{16'h5019, 16'h7777, 4'b0010, 2'b00, 16'h4980, 4'd9, 4'b0000, 4'b0000};
    rst_n = 1'b0;
    bus.cfg_we = 1'b0;
    bus.cfg_c1 = 4'h0;
    bus.cfg_c2 = 4'h0;
    bus.out_ready = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 4'h0, 2'd0);
    tick();
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    chk("rst_max_exp", 32'(bus.max_exp), 32'd0);
    chk("rst_offsets", 32'(bus.exp_offset_num), 32'd0);
    chk("rst_significand", 32'(bus.significand), 32'd0);
    chk("rst_sign", 32'(bus.sign), 32'd0);
    chk("rst_c1", 32'(bus.complement_sign1), 32'd0);
    chk("rst_c2", 32'(bus.complement_sign2), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    foreach (vec[i]) begin
      drive(1'b1, vec[i].exp, vec[i].sig, vec[i].sign, vec[i].mode);
      tick();
      bus.in_valid = 1'b0;
      chk("vec_latency", 32'(bus.out_valid), 32'd0);
      tick();
      chk("vec_valid", 32'(bus.out_valid), 32'd1);
      chk("vec_offsets", 32'(bus.exp_offset_num), 32'(vec[i].off));
      chk("vec_max_exp", 32'(bus.max_exp), 32'(vec[i].mx));
      chk("vec_significand", 32'(bus.significand), 32'(vec[i].sig));
      chk("vec_sign", 32'(bus.sign), 32'(vec[i].sign));
      chk("vec_c1", 32'(bus.complement_sign1), 32'(vec[i].c1));
      chk("vec_c2", 32'(bus.complement_sign2), 32'(vec[i].c2));
      tick();
    end
    do_reset();
    emitted.delete();
    bus.out_ready = 1'b0;
    gi = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'h3210 + 16'(gi), 16'hB000 + 16'(gi), 4'(gi), 2'd1);
      a0 = accepts;
      tick();
      if (accepts != a0) gi++;
    end
    chk("bp_accepts", 32'(gi), 32'd2);
    chk("bp_stall_cnt", 32'(bus.stall_cnt), 32'd6);
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(gi < 5, 16'h3210 + 16'(gi), 16'hB000 + 16'(gi), 4'(gi), 2'd1);
      a0 = accepts;
      tick();
      if (accepts != a0) gi++;
    end
    chk("bp_emit_count", 32'(emitted.size()), 32'd5);
    if (emitted.size() == 5) begin
      foreach (emitted[k]) chk("bp_order", 32'(emitted[k].sig), 32'hB000 + 32'(k));
      chk("bp_no_gaps", 32'(emitted[4].t - emitted[0].t), 32'd4);
    end
    do_reset();
    emitted.delete();
    bus.out_ready = 1'b1;
    drive(1'b1, 16'h1111, 16'h00C1, 4'h0, 2'd3);
    bus.cfg_we = 1'b1;
    bus.cfg_c1 = 4'b0110;
    bus.cfg_c2 = 4'b1001;
    tick();
    bus.cfg_we = 1'b0;
    drive(1'b1, 16'h2222, 16'h00C2, 4'h0, 2'd3);
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("cfg_emit_count", 32'(emitted.size()), 32'd2);
    if (emitted.size() == 2) begin
      chk("cfg_old_c1", 32'(emitted[0].c1), 32'h0);
      chk("cfg_old_c2", 32'(emitted[0].c2), 32'hF);
      chk("cfg_new_c1", 32'(emitted[1].c1), 32'h6);
      chk("cfg_new_c2", 32'(emitted[1].c2), 32'h9);
    end
    emitted.delete();
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h4444, 16'hD001, 4'h1, 2'd0);
    tick();
    drive(1'b1, 16'h5555, 16'hD002, 4'h2, 2'd0);
    tick();
    chk("mid_full_in_ready", 32'(bus.in_ready), 32'd0);
    do_reset();
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("mid_rst_no_stale", 32'(emitted.size()), 32'd0);
    for (int i = 0; i < 600; i++) begin
      rst_n = $urandom_range(0, 99) != 0;
      bus.out_ready = $urandom_range(0, 3) != 0;
      bus.cfg_we = $urandom_range(0, 7) == 0;
      bus.cfg_c1 = 4'($urandom);
      bus.cfg_c2 = 4'($urandom);
      drive(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 4'($urandom), 2'($urandom));
      tick();
    end
    rst_n = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
